// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared constants for the PWM generator: register map, CTRL bit
//          positions and default counter width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int DEFAULT_CNT_W = 16;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_INVERT_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_DONE_BIT = 0;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_generator_if.sv
// ============================================================================
// Module : pwm_generator_if
// Brief  : Avalon-MM slave bus bundle for the PWM generator register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_generator_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface : pwm_generator_if

`default_nettype wire

// File: rtl/pwm_tick_gen.sv
// ============================================================================
// Module : pwm_tick_gen
// Brief  : Samples the divider output in the clock_in domain and produces a
//          one-cycle tick per rising edge, or a tick every cycle in bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_tick_gen (
    input  wire logic clock_in,
    input  wire logic reset,
    input  wire logic prescale_clk,
    input  wire logic div_bypass,
    output logic      tick
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= prescale_clk;
            r_s2 <= r_s1;
        end
    end

    // A divider ratio of 0 means every system cycle is a prescaled cycle.
    assign tick = div_bypass | (r_s1 & ~r_s2);

endmodule : pwm_tick_gen

`default_nettype wire

// File: rtl/pwm_generator.sv
// ============================================================================
// Module : pwm_generator
// Brief  : Double-buffered PWM with Avalon-MM register file. Optional
//          period-done interrupt is built when PWM_IRQ_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter bit IDLE_LVL = 1'b0
) (
    input  wire logic       clock_in,
    input  wire logic       reset,
    input  wire logic       prescale_clk,
    input  wire logic       div_bypass,
    pwm_generator_if.slave  bus,
    output logic            pwm_out,
    output logic            irq
);

    logic             w_tick;
    logic             r_enable;
    logic             r_invert;
    logic             w_irq_en;
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rd_mux;
    logic [CNT_W-1:0] w_wdata;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_disable;
    logic             w_boundary;
    logic             w_raw;

    pwm_tick_gen u_tick_gen (
        .clock_in     (clock_in),
        .reset        (reset),
        .prescale_clk (prescale_clk),
        .div_bypass   (div_bypass),
        .tick         (w_tick)
    );

    assign w_wdata     = bus.writedata[CNT_W-1:0];
    assign w_wr_ctrl   = bus.write && (bus.address == ADDR_CTRL);
    assign w_wr_status = bus.write && (bus.address == ADDR_STATUS);
    assign w_disable   = w_wr_ctrl && !bus.writedata[CTRL_ENABLE_BIT];
    assign w_boundary  = r_enable && w_tick && (r_cnt == r_per_act);
    assign w_raw       = r_enable ? (r_cnt < r_duty_act) : IDLE_LVL;

    generate
        if (CNT_W < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^bus.writedata[31:CNT_W];
        end
    endgenerate

    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.address)
            ADDR_CTRL: begin
                w_rd_mux[CTRL_ENABLE_BIT] = r_enable;
                w_rd_mux[CTRL_INVERT_BIT] = r_invert;
                w_rd_mux[CTRL_IRQ_EN_BIT] = w_irq_en;
            end
            ADDR_PERIOD: w_rd_mux = 32'(r_per_sh);
            ADDR_DUTY:   w_rd_mux = 32'(r_duty_sh);
            default: begin
                w_rd_mux[31:16]           = 16'(r_cnt);
                w_rd_mux[STATUS_DONE_BIT] = r_done;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_invert   <= 1'b0;
            r_per_sh   <= '0;
            r_duty_sh  <= '0;
            r_per_act  <= '0;
            r_duty_act <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_readdata <= 32'd0;
            pwm_out    <= IDLE_LVL;
        end else begin
            if (bus.write) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        r_enable <= bus.writedata[CTRL_ENABLE_BIT];
                        r_invert <= bus.writedata[CTRL_INVERT_BIT];
                    end
                    ADDR_PERIOD: r_per_sh  <= w_wdata;
                    ADDR_DUTY:   r_duty_sh <= w_wdata;
                    default: ;
                endcase
            end

            // Set wins over a same-cycle clear.
            if (w_boundary) begin
                r_done <= 1'b1;
            end else if (w_wr_status && bus.writedata[STATUS_DONE_BIT]) begin
                r_done <= 1'b0;
            end

            // Shadows only reach the active copies at a boundary or while idle,
            // so a boundary always sees the shadow value from before this edge.
            if (!r_enable || w_disable) begin
                r_cnt      <= '0;
                r_per_act  <= r_per_sh;
                r_duty_act <= r_duty_sh;
            end else if (w_tick) begin
                if (r_cnt == r_per_act) begin
                    r_cnt      <= '0;
                    r_per_act  <= r_per_sh;
                    r_duty_act <= r_duty_sh;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            pwm_out <= w_raw ^ r_invert;

            if (bus.read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign bus.readdata = r_readdata;

`ifdef PWM_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
            end
            irq <= r_done & r_irq_en;
        end
    end

    assign w_irq_en = r_irq_en;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

endmodule : pwm_generator

`default_nettype wire
